// File: rtl/preg_freelist_if.sv
// Rename/retire side bundle for the physical-register free list.
// Alloc, free and commit lanes plus the flush and occupancy view.
interface preg_freelist_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int NPREG       = 64,
    parameter int NAREG       = 32
);
    localparam int AW = $clog2(NPREG);
    localparam int CW = $clog2(NPREG - NAREG) + 1;

    logic [FETCH_WIDTH-1:0]         alloc_req;
    logic                           alloc_en;
    logic                           alloc_ok;
    logic [FETCH_WIDTH-1:0][AW-1:0] alloc_id;
    logic [FETCH_WIDTH-1:0]         free_valid;
    logic [FETCH_WIDTH-1:0][AW-1:0] free_id;
    logic [FETCH_WIDTH-1:0]         commit_valid;
    logic                           flush;
    logic [CW-1:0]                  free_count;

    modport master (
        output alloc_req, alloc_en, free_valid, free_id,
        output commit_valid, flush,
        input  alloc_ok, alloc_id, free_count
    );

    modport slave (
        input  alloc_req, alloc_en, free_valid, free_id,
        input  commit_valid, flush,
        output alloc_ok, alloc_id, free_count
    );
endinterface

// File: rtl/preg_freelist.sv
// Circular free list of physical registers with speculative and
// committed heads; flush rewinds the speculative head.
module preg_freelist #(
    parameter int FETCH_WIDTH = 4,
    parameter int NPREG       = 64,
    parameter int NAREG       = 32
) (
    input logic            clk,
    input logic            reset,
    preg_freelist_if.slave fl
);
    localparam int NFREE = NPREG - NAREG;
    localparam int IW    = $clog2(NFREE);
    localparam int PW    = IW + 1;
    localparam int AW    = $clog2(NPREG);

    typedef logic [PW-1:0] ptr_t;

    logic [AW-1:0] mem [NFREE];
    ptr_t          spec_head;
    ptr_t          arch_head;
    ptr_t          tail;

    ptr_t          req_pre [FETCH_WIDTH+1];
    ptr_t          free_pre[FETCH_WIDTH+1];
    ptr_t          cmt_pre [FETCH_WIDTH+1];
    logic [IW-1:0] ridx    [FETCH_WIDTH];
    logic [IW-1:0] widx    [FETCH_WIDTH];

    ptr_t req_n;
    ptr_t free_n;
    ptr_t cmt_n;
    ptr_t free_count;
    ptr_t arch_next;
    ptr_t spec_occ;
    ptr_t tail_occ;
    logic grant;

    // Prefix popcounts compact the set lanes onto consecutive slots.
    always_comb begin
        req_pre[0]  = '0;
        free_pre[0] = '0;
        cmt_pre[0]  = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            req_pre[i+1]  = req_pre[i]  + ptr_t'(fl.alloc_req[i]);
            free_pre[i+1] = free_pre[i] + ptr_t'(fl.free_valid[i]);
            cmt_pre[i+1]  = cmt_pre[i]  + ptr_t'(fl.commit_valid[i]);
        end
    end

    assign req_n      = req_pre[FETCH_WIDTH];
    assign free_n     = free_pre[FETCH_WIDTH];
    assign cmt_n      = cmt_pre[FETCH_WIDTH];
    assign free_count = tail - spec_head;
    assign arch_next  = arch_head + cmt_n;
    assign spec_occ   = spec_head - arch_head;
    assign tail_occ   = tail - arch_head;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            ridx[i] = IW'(spec_head + req_pre[i]);
            widx[i] = IW'(tail + free_pre[i]);
        end
    end

    always_comb begin
        fl.alloc_ok = (req_n <= free_count) & ~fl.flush;
        for (int i = 0; i < FETCH_WIDTH; i++)
            fl.alloc_id[i] = mem[ridx[i]];
    end

    assign fl.free_count = free_count;
    assign grant         = fl.alloc_en & fl.alloc_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NFREE; k++)
                mem[k] <= AW'(NAREG + k);
            spec_head <= '0;
            arch_head <= '0;
            tail      <= ptr_t'(NFREE);
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++)
                if (fl.free_valid[i])
                    mem[widx[i]] <= fl.free_id[i];
            tail      <= tail + free_n;
            arch_head <= arch_next;
            if (fl.flush)
                spec_head <= arch_next;
            else if (grant)
                spec_head <= spec_head + req_n;
        end
    end

    a_no_overfree : assert property (
        @(posedge clk) disable iff (reset)
        (int'(free_count) + int'(free_n)) <= NFREE
    ) else $fatal(1, "free list overfilled");

    a_ptr_order : assert property (
        @(posedge clk) disable iff (reset)
        spec_occ <= tail_occ
    );

    a_commit_bound : assert property (
        @(posedge clk) disable iff (reset)
        cmt_n <= spec_occ
    );
endmodule

// File: tb/tb_preg_freelist.sv
// Directed vector table plus hand sequences for drain, flush,
// wrap-around FIFO order and asynchronous reset.
module tb_preg_freelist;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    preg_freelist_if bus ();

    preg_freelist dut (
        .clk   (clk),
        .reset (reset),
        .fl    (bus)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic        en;
        logic [3:0]  fv;
        logic [23:0] fid;
        logic [3:0]  cv;
        logic        fl;
        logic        ok;
        logic [23:0] ids;
        int          fc;
    } vec_t;

    int total  = 0;
    int passed = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [23:0] l4(int a, int b, int c, int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic vec_t mk(bit r, logic [3:0] req, logic en,
                                logic [3:0] fv, logic [23:0] fid,
                                logic [3:0] cv, logic f, logic ok,
                                logic [23:0] ids, int fc);
        vec_t v;
        v.rst = r; v.req = req; v.en = en; v.fv = fv; v.fid = fid;
        v.cv = cv; v.fl = f; v.ok = ok; v.ids = ids; v.fc = fc;
        return v;
    endfunction

    task automatic idle();
        bus.alloc_req    = '0;
        bus.alloc_en     = 1'b0;
        bus.free_valid   = '0;
        bus.free_id      = '0;
        bus.commit_valid = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    vec_t vt[14];
    int   freeq[$];
    int   outq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][5:0] exp_ids;
        logic [3:0][5:0] fids;
        int e;

        reset = 1'b1;
        idle();

        vt[0]  = mk(1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 1, 0, 32);
        vt[1]  = mk(0, 4'hF, 1, 4'h0, 0, 4'h0, 0, 1, l4(32,33,34,35), 32);
        vt[2]  = mk(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 1, 0, 28);
        vt[3]  = mk(1, 4'hA, 1, 4'h0, 0, 4'h0, 0, 1, l4(0,32,0,33), 32);
        vt[4]  = mk(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 1, 0, 30);
        vt[5]  = mk(1, 4'hF, 1, 4'h0, 0, 4'h0, 0, 1, l4(32,33,34,35), 32);
        vt[6]  = mk(0, 4'hF, 1, 4'h0, 0, 4'h0, 0, 1, l4(36,37,38,39), 28);
        vt[7]  = mk(0, 4'h0, 0, 4'h0, 0, 4'hF, 0, 1, 0, 24);
        vt[8]  = mk(0, 4'h0, 0, 4'h0, 0, 4'h3, 1, 0, 0, 24);
        vt[9]  = mk(0, 4'h1, 1, 4'h0, 0, 4'h0, 0, 1, l4(38,0,0,0), 26);
        vt[10] = mk(0, 4'hF, 1, 4'h0, 0, 4'h0, 1, 0, 0, 25);
        vt[11] = mk(0, 4'h0, 0, 4'h5, l4(3,0,9,0), 4'h0, 0, 1, 0, 26);
        vt[12] = mk(0, 4'h6, 0, 4'h0, 0, 4'h0, 0, 1, l4(0,38,39,0), 28);
        vt[13] = mk(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 1, 0, 28);

        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (vt[k].rst) pulse_reset();
            bus.alloc_req    = vt[k].req;
            bus.alloc_en     = vt[k].en;
            bus.free_valid   = vt[k].fv;
            bus.free_id      = vt[k].fid;
            bus.commit_valid = vt[k].cv;
            bus.flush        = vt[k].fl;
            #1;
            chk($sformatf("v%0d ok", k), int'(bus.alloc_ok), int'(vt[k].ok));
            chk($sformatf("v%0d count", k), int'(bus.free_count), vt[k].fc);
            exp_ids = vt[k].ids;
            if (vt[k].ok)
                for (int i = 0; i < 4; i++)
                    if (vt[k].req[i])
                        chk($sformatf("v%0d id%0d", k, i),
                            int'(bus.alloc_id[i]), int'(exp_ids[i]));
        end

        // Drain to empty, then a free and alloc collide at count 0.
        @(negedge clk);
        idle();
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            bus.alloc_req = 4'hF;
            bus.alloc_en  = 1'b1;
            #1;
            for (int i = 0; i < 4; i++)
                chk($sformatf("drain c%0d id%0d", c, i),
                    int'(bus.alloc_id[i]), 32 + 4 * c + i);
            @(negedge clk);
        end
        bus.alloc_req  = 4'h1;
        bus.free_valid = 4'h1;
        fids           = '0;
        fids[0]        = 6'd7;
        bus.free_id    = fids;
        #1;
        chk("empty count", int'(bus.free_count), 0);
        chk("empty ok", int'(bus.alloc_ok), 0);
        @(negedge clk);
        bus.free_valid = '0;
        #1;
        chk("refill ok", int'(bus.alloc_ok), 1);
        chk("refill id", int'(bus.alloc_id[0]), 7);
        chk("refill count", int'(bus.free_count), 1);
        @(negedge clk);
        idle();
        #1;
        chk("re-empty count", int'(bus.free_count), 0);

        // Steady-state wrap: ids must come back in the order they were freed.
        @(negedge clk);
        pulse_reset();
        freeq.delete();
        outq.delete();
        for (int k = 32; k < 64; k++) freeq.push_back(k);
        for (int c = 0; c < 4; c++) begin
            bus.alloc_req = 4'hF;
            bus.alloc_en  = 1'b1;
            #1;
            for (int i = 0; i < 4; i++) begin
                e = freeq.pop_front();
                chk($sformatf("prime c%0d id%0d", c, i),
                    int'(bus.alloc_id[i]), e);
                outq.push_back(e);
            end
            @(negedge clk);
        end
        for (int c = 0; c < 100; c++) begin
            bus.alloc_req    = 4'hF;
            bus.alloc_en     = 1'b1;
            bus.commit_valid = 4'hF;
            bus.free_valid   = 4'hF;
            for (int i = 0; i < 4; i++) begin
                e       = outq.pop_front();
                fids[i] = 6'(e);
                freeq.push_back(e);
            end
            bus.free_id = fids;
            #1;
            chk($sformatf("wrap c%0d count", c), int'(bus.free_count), 16);
            for (int i = 0; i < 4; i++) begin
                e = freeq.pop_front();
                chk($sformatf("wrap c%0d id%0d", c, i),
                    int'(bus.alloc_id[i]), e);
                outq.push_back(e);
            end
            @(negedge clk);
        end

        // Reset between edges must restore the image with no clock.
        idle();
        bus.alloc_req = 4'h1;
        #2 reset = 1'b1;
        #1;
        chk("async count", int'(bus.free_count), 32);
        chk("async id", int'(bus.alloc_id[0]), 32);
        chk("async ok", int'(bus.alloc_ok), 1);
        reset = 1'b0;
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
